ysyx_24110015_ifu_prefetch: RTL
===============================

// Module: ysyx_24110015_ifu_prefetch
// PURPOSE
//  Parametrised, multi-cycle instruction fetch unit.
//  - Holds the fetch PC and issues in-order word reads on a valid/ready memory request channel.
//  - Collects in-order responses into a DEPTH-entry prefetch FIFO and hands {pc,inst,err} to the IDU over a valid/ready port.
//  - Supports PC redirect (branch/exception) with flush and discard of stale in-flight responses.
// PARAMETERS
//  XLEN      32            address/instruction width
//  RESET_PC  32'h8000_0000 fetch PC after reset
//  DEPTH     4             prefetch FIFO entries; power of two, >=2; also caps requests in flight
// PORTS
//  clk            in   1     clock, rising edge
//  rst            in   1     asynchronous, active-low reset
//  fetch_en       in   1     1 = allowed to issue new requests
//  redirect_valid in   1     flush and restart fetch at redirect_pc
//  redirect_pc    in   XLEN  new fetch PC; bits[1:0] ignored (forced 0)
//  mem_req_valid  out  1     read request valid
//  mem_req_ready  in   1     memory accepts request
//  mem_req_addr   out  XLEN  word address of request
//  mem_rsp_valid  in   1     read response; always accepted, no ready
//  mem_rsp_data   in   XLEN  instruction word
//  mem_rsp_err    in   1     access fault for this response
//  out_valid      out  1     FIFO head valid
//  out_ready      in   1     IDU accepts head
//  out_pc         out  XLEN  PC of head instruction
//  out_inst       out  XLEN  head instruction
//  out_err        out  1     head carries access fault
// BEHAVIOUR
//  Reset (rst=0, async)
//  - state=BOOT; fetch_pc=rsp_pc=RESET_PC; inflight=drop_cnt=count=0.
//  - mem_req_valid=0, out_valid=0; out_pc/out_inst/out_err=0; mem_req_addr=RESET_PC.
//  FSM
//  - BOOT -> RUN after one clock.
//  - RUN -> HALT when a non-dropped response has mem_rsp_err=1.
//  - HALT -> RUN only on redirect_valid.
//  - redirect_valid in any state -> RUN.
//  Issue
//  - mem_req_valid = (state==RUN) & fetch_en & (inflight+count < DEPTH); mem_req_addr = fetch_pc; both registered-stable.
//  - Once asserted, valid and addr hold until mem_req_ready, even if fetch_en drops.
//  - req_fire = valid & ready: fetch_pc += 4 (mod 2^XLEN wrap); inflight++.
//  - A redirect overrides the hold.
//  Response
//  - Each mem_rsp_valid: inflight--.
//  - If drop_cnt>0: drop_cnt--, data discarded.
//  - Else push {rsp_pc, data, err} into FIFO; rsp_pc += 4.
//  - Push never overflows: guaranteed by the credit rule.
//  - Response with inflight==0 is a protocol error: ignored.
//  Output
//  - FIFO head is registered; out_valid = count!=0.
//  - Response-to-out_valid latency: 1 cycle.
//  - Pop when out_valid & out_ready. Push and pop in the same cycle with count==DEPTH is legal (credit rule).
//  - Outputs stable while out_valid & !out_ready.
//  Redirect (highest priority, same edge)
//  - FIFO cleared: out_valid=0 next cycle, head lost even if popped this cycle.
//  - fetch_pc=rsp_pc=redirect_pc & ~3.
//  - drop_cnt <= inflight + req_fire - rsp_fire: every request still outstanding after this edge is dropped.
//  - Response arriving in the redirect cycle is discarded.
//  - A request handshaken in the redirect cycle is counted as dropped.
//  - mem_req_valid is deasserted for the cycle after redirect; issue resumes at redirect_pc next cycle.
//  Widths
//  - count, inflight and drop_cnt are $clog2(DEPTH+1) bits.
//  - inflight+count compare is done at that width plus 1.
//  Reset mid-operation
//  - All state cleared immediately.
//  - Responses for pre-reset requests must not be driven by memory after reset.
// TESTING
//  1 Reset, fetch_en=1, ready=1, 1-cycle response
//    -> requests 0x80000000, 0x80000004 ... back to back;
//       out_pc/out_inst in order; first out_valid 3 cycles after rst release.
//  2 out_ready=0, DEPTH=4
//    -> exactly 4 requests issued, then mem_req_valid=0;
//       one pop re-enables exactly one request.
//  3 Redirect to 0x80001002 with 3 requests in flight
//    -> 3 responses discarded; next out_pc=0x80001000; no stale inst ever reaches out.
//  4 mem_rsp_err=1 on the 2nd response
//    -> out_err=1 with out_pc=0x80000004; no further requests until redirect; redirect resumes fetch.
//  5 Redirect coincident with req_fire, rsp_valid and pop
//    -> FIFO empty next cycle; drop_cnt accounts both; first kept out_pc = redirect_pc.
//  6 fetch_pc=0xFFFFFFFC
//    -> next request address 0x00000000 (wrap); async reset mid-burst clears all outputs without a clock.

Source files
------------

// File: rtl/ysyx_24110015_ifu_prefetch.sv
// ysyx_24110015_ifu_prefetch
//   Multi-cycle instruction fetch unit with a small prefetch FIFO.
//   Keeps the fetch PC and issues in-order word reads on a valid/ready
//   request channel. In-order responses are tagged with their PC and queued
//   in a DEPTH-entry FIFO whose head is presented to the IDU. A redirect
//   flushes the FIFO and marks all outstanding reads to be discarded.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   fetch_en                 allow new requests to be issued
//   redirect_valid/_pc       flush and restart fetch at redirect_pc (word aligned)
//   mem_req_valid/ready/addr read request channel
//   mem_rsp_valid/data/err   read response (always accepted)
//   out_valid/ready          FIFO head handshake toward the IDU
//   out_pc/inst/err          FIFO head contents
module ysyx_24110015_ifu_prefetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    input  logic            mem_rsp_err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst,
    output logic            out_err
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [XLEN-1:0] fetch_pc, rsp_pc;
    logic [CW-1:0]   inflight, drop_cnt, count;
    logic [CW-1:0]   inflight_nx, count_nx;
    logic [CW:0]     credit_sum;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic            req_fire, rsp_fire, push, pop;
    logic            issue_allow, req_valid_nx;

    logic [XLEN-1:0] fifo_pc   [DEPTH];
    logic [XLEN-1:0] fifo_inst [DEPTH];
    logic            fifo_err  [DEPTH];

    // Handshakes. A response with nothing outstanding is a protocol error
    // and is ignored entirely.
    assign req_fire = mem_req_valid & mem_req_ready;
    assign rsp_fire = mem_rsp_valid & (inflight != '0);
    assign push     = rsp_fire & (drop_cnt == '0) & ~redirect_valid;
    assign pop      = out_valid & out_ready;

    assign inflight_nx = inflight + CW'(req_fire) - CW'(rsp_fire);
    assign count_nx    = redirect_valid ? '0 : count + CW'(push) - CW'(pop);
    // Credit: outstanding reads plus queued entries never exceed DEPTH, so
    // every response that is kept always finds a free FIFO slot.
    assign credit_sum  = {1'b0, inflight_nx} + {1'b0, count_nx};

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= BOOT;
        else      state <= state_nx;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        state_nx = state;
        if (redirect_valid) begin
            state_nx = RUN;
        end else begin
            unique case (state)
                BOOT:    state_nx = RUN;
                RUN:     if (push && mem_rsp_err) state_nx = HALT;
                HALT:    state_nx = HALT;
                default: state_nx = BOOT;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        issue_allow = 1'b0;
        if (state_nx == RUN) issue_allow = 1'b1;
    end

    // Request valid is registered. A pending request holds until accepted;
    // a redirect cancels it and leaves one idle cycle before reissue.
    always_comb begin
        req_valid_nx = 1'b0;
        if (redirect_valid)
            req_valid_nx = 1'b0;
        else if (mem_req_valid && !mem_req_ready)
            req_valid_nx = 1'b1;
        else
            req_valid_nx = issue_allow & fetch_en & (credit_sum < DEPTH_C);
    end

    // ---------------- Control / pointer state ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_valid <= 1'b0;
            fetch_pc      <= RESET_PC;
            rsp_pc        <= RESET_PC;
            inflight      <= '0;
            drop_cnt      <= '0;
            count         <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
        end else begin
            mem_req_valid <= req_valid_nx;
            inflight      <= inflight_nx;
            count         <= count_nx;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~XLEN'(3);
                rsp_pc   <= redirect_pc & ~XLEN'(3);
                // Everything still outstanding after this edge, including a
                // request accepted right now, belongs to the old stream.
                drop_cnt <= inflight_nx;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
                if (rsp_fire && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                if (push) begin
                    rsp_pc <= rsp_pc + XLEN'(4);
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // ---------------- FIFO storage ----------------
    // NOTE: the storage array has no reset; an entry is only observable
    // once count says it was written, and outputs are gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= rsp_pc;
            fifo_inst[wr_ptr] <= mem_rsp_data;
            fifo_err[wr_ptr]  <= mem_rsp_err;
        end
    end

    assign mem_req_addr = fetch_pc;
    assign out_valid    = (count != '0);
    assign out_pc       = out_valid ? fifo_pc[rd_ptr]   : '0;
    assign out_inst     = out_valid ? fifo_inst[rd_ptr] : '0;
    assign out_err      = out_valid & fifo_err[rd_ptr];

endmodule
